// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with MEM/WB operand forwarding into the E stage.
// A flush, or an empty decode slot when not stalled, loads a zeroed bubble.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        ValidD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ExtImmD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic [2:0]  ALUFuncD,
  input  logic        OpBSrcD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        BranchD,
  input  logic [1:0]  ResultSrcD,
  input  logic [31:0] ALUResultM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [31:0] ResultW,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  output logic [31:0] OpA,
  output logic [31:0] OpB,
  output logic [31:0] ExtImmE,
  output logic [2:0]  ALUFuncE,
  output logic        OpBSrcE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        ValidE,
  output logic [1:0]  ResultSrcE
);

  logic [31:0] rd1_q;
  logic [31:0] rd2_q;
  logic        load_bubble;

  assign load_bubble = FlushE || (!StallE && !ValidD);

  // MEM beats WB; index 0 is hardwired zero and never forwarded.
  always_comb begin
    OpA = rd1_q;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
      OpA = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
      OpA = ResultW;

    OpB = rd2_q;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
      OpB = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
      OpB = ResultW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || load_bubble) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      ExtImmE    <= '0;
      ALUFuncE   <= '0;
      OpBSrcE    <= 1'b0;
      Rs1E       <= '0;
      Rs2E       <= '0;
      RdE        <= '0;
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      BranchE    <= 1'b0;
      ValidE     <= 1'b0;
      ResultSrcE <= '0;
    end else if (StallE) begin
      // Absorb forwarded values so a producer retiring mid-stall is not lost.
      rd1_q <= OpA;
      rd2_q <= OpB;
    end else begin
      rd1_q      <= RD1D;
      rd2_q      <= RD2D;
      ExtImmE    <= ExtImmD;
      ALUFuncE   <= ALUFuncD;
      OpBSrcE    <= OpBSrcD;
      Rs1E       <= Rs1D;
      Rs2E       <= Rs2D;
      RdE        <= RdD;
      RegWriteE  <= RegWriteD;
      MemWriteE  <= MemWriteD;
      BranchE    <= BranchD;
      ValidE     <= ValidD;
      ResultSrcE <= ResultSrcD;
    end
  end

endmodule
